io_timer_port: RTL and testbench

IO_TIMER_PORT -- requirements
Module: io_timer_port

---
 rtl/io_timer_port.sv | 164 ++++++++++++++++
 tb/tb_io_timer_port.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_timer_port.sv
// io_timer_port: memory-mapped IO port with an LED register, a synchronized
// switch input and a 32-bit down-counting timer that can raise an interrupt.
//
// Ports
//   clk         system clock, all state updates on the rising edge
//   rst         synchronous active-high reset
//   io_ce_i     IO chip enable (1 = access this cycle)
//   iowenb_i    1 = write, 0 = read (meaningful only with io_ce_i = 1)
//   ioaddr_i    IO address, register select on bits [4:2]
//   io_wdata_i  write data
//   io_rdata_o  combinational read data (0 when not reading)
//   switch_i    asynchronous board switches
//   led_o       LED register
//   irq_o       timer interrupt level (expired AND ien)
//   dbg_state   timer state for observation: 0 IDLE, 1 RUN, 2 EXPIRED
//
// Register map on ioaddr_i[4:2]:
//   0 LED (RW [15:0])  1 SW (RO)  2 TCTRL (RW: b0 en, b1 autoreload, b2 ien)
//   3 TLOAD (RW)  4 TCOUNT (RO)  5 TSTAT (b0 expired, write-1-to-clear)
//   6, 7 unmapped
//
// Access protocol: any cycle with io_ce_i = 1 is a complete access. A write
// (iowenb_i = 1) is captured at that cycle's rising edge; a read
// (iowenb_i = 0) returns data combinationally in the same cycle and has no
// side effects. There is no backpressure: the port is always ready.
module io_timer_port (
    input  logic        clk,
    input  logic        rst,
    input  logic        io_ce_i,
    input  logic        iowenb_i,
    input  logic [31:0] ioaddr_i,
    input  logic [31:0] io_wdata_i,
    output logic [31:0] io_rdata_o,
    input  logic [15:0] switch_i,
    output logic [15:0] led_o,
    output logic        irq_o,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } timer_state_t;

    localparam logic [2:0] A_LED    = 3'd0;
    localparam logic [2:0] A_SW     = 3'd1;
    localparam logic [2:0] A_TCTRL  = 3'd2;
    localparam logic [2:0] A_TLOAD  = 3'd3;
    localparam logic [2:0] A_TCOUNT = 3'd4;
    localparam logic [2:0] A_TSTAT  = 3'd5;

    timer_state_t state;
    logic [15:0]  led_q;
    logic [15:0]  sw_meta;
    logic [15:0]  sw_sync;
    logic [2:0]   tctrl;
    logic [31:0]  tload;
    logic [31:0]  tcount;
    logic         expired;

    logic [2:0]   reg_sel;
    logic         wr_en;
    logic         ctrl_wr;
    logic         stat_clr;
    logic [31:0]  load_next;
    logic         ar_eff;
    logic         stop_req;
    logic         expire_evt;
    logic         unused_addr_bits;

    assign reg_sel   = ioaddr_i[4:2];
    assign wr_en     = io_ce_i & iowenb_i;
    assign ctrl_wr   = wr_en && (reg_sel == A_TCTRL);
    assign stat_clr  = wr_en && (reg_sel == A_TSTAT) && io_wdata_i[0];
    // A start or reload on the same edge as a TLOAD write uses the new value.
    assign load_next = (wr_en && (reg_sel == A_TLOAD)) ? io_wdata_i : tload;
    // Autoreload written on the expiring edge already applies to that expiry.
    assign ar_eff    = ctrl_wr ? io_wdata_i[1] : tctrl[1];
    // Writing en = 0 while running stops the timer and suppresses expiry.
    assign stop_req  = ctrl_wr && !io_wdata_i[0];
    assign expire_evt = (state == RUN) && !stop_req && (tcount == 32'd0);

    assign unused_addr_bits = ^{ioaddr_i[31:5], ioaddr_i[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            led_q   <= 16'h0;
            sw_meta <= 16'h0;
            sw_sync <= 16'h0;
            tctrl   <= 3'b000;
            tload   <= 32'h0;
            tcount  <= 32'h0;
            expired <= 1'b0;
        end else begin
            sw_meta <= switch_i;
            sw_sync <= sw_meta;

            if (wr_en && (reg_sel == A_LED)) begin
                led_q <= io_wdata_i[15:0];
            end
            tload <= load_next;

            // Set has priority over write-1-to-clear.
            if (expire_evt) begin
                expired <= 1'b1;
            end else if (stat_clr) begin
                expired <= 1'b0;
            end

            if (ctrl_wr) begin
                tctrl <= io_wdata_i[2:0];
            end

            case (state)
                IDLE, EXPIRED: begin
                    if (ctrl_wr) begin
                        if (io_wdata_i[0]) begin
                            state  <= RUN;
                            tcount <= load_next;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                RUN: begin
                    if (stop_req) begin
                        state <= IDLE;
                    end else if (tcount != 32'd0) begin
                        tcount <= tcount - 32'd1;
                    end else if (ar_eff) begin
                        tcount <= load_next;
                    end else begin
                        // One-shot expiry: count stays at 0 and en drops.
                        state    <= EXPIRED;
                        tctrl[0] <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        io_rdata_o = 32'h0;
        if (io_ce_i && !iowenb_i) begin
            case (reg_sel)
                A_LED:    io_rdata_o = {16'h0, led_q};
                A_SW:     io_rdata_o = {16'h0, sw_sync};
                A_TCTRL:  io_rdata_o = {29'h0, tctrl};
                A_TLOAD:  io_rdata_o = tload;
                A_TCOUNT: io_rdata_o = tcount;
                A_TSTAT:  io_rdata_o = {31'h0, expired};
                default:  io_rdata_o = 32'h0;
            endcase
        end
    end

    assign led_o     = led_q;
    assign irq_o     = expired & tctrl[2];
    assign dbg_state = state;

endmodule

// File: tb/tb_io_timer_port.sv
// Testbench for io_timer_port: directed scenarios followed by randomized
// register traffic, all checked against a cycle-indexed reference model.
// The timer model tracks the start/reload edge and the period length and
// derives TCOUNT and expiry from elapsed edges with plain arithmetic.
module tb_io_timer_port;

    logic        clk;
    logic        rst;
    logic        io_ce_i;
    logic        iowenb_i;
    logic [31:0] ioaddr_i;
    logic [31:0] io_wdata_i;
    logic [31:0] io_rdata_o;
    logic [15:0] switch_i;
    logic [15:0] led_o;
    logic        irq_o;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_EXP  = 2'd2;

    localparam logic [31:0] AD_LED    = 32'h00;
    localparam logic [31:0] AD_SW     = 32'h04;
    localparam logic [31:0] AD_TCTRL  = 32'h08;
    localparam logic [31:0] AD_TLOAD  = 32'h0C;
    localparam logic [31:0] AD_TCOUNT = 32'h10;
    localparam logic [31:0] AD_TSTAT  = 32'h14;

    io_timer_port dut (
        .clk        (clk),
        .rst        (rst),
        .io_ce_i    (io_ce_i),
        .iowenb_i   (iowenb_i),
        .ioaddr_i   (ioaddr_i),
        .io_wdata_i (io_wdata_i),
        .io_rdata_o (io_rdata_o),
        .switch_i   (switch_i),
        .led_o      (led_o),
        .irq_o      (irq_o),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    longint      m_edge = 0;     // edges seen so far
    longint      m_anchor = 0;   // edge at which the current period began
    longint      m_per = 0;      // load value of the current period
    bit          m_running = 0;
    logic [31:0] m_frozen = 0;
    logic [31:0] m_load = 0;
    logic [15:0] m_led = 0;
    logic [2:0]  m_ctrl = 0;
    bit          m_expired = 0;
    logic [1:0]  m_state = ST_IDLE;
    logic [15:0] sw_q[$] = '{16'h0, 16'h0};

    function automatic logic [31:0] m_count();
        if (m_running) return 32'(m_per - (m_edge - m_anchor));
        return m_frozen;
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            3'd0: return {16'h0, m_led};
            3'd1: return {16'h0, sw_q[0]};
            3'd2: return {29'h0, m_ctrl};
            3'd3: return m_load;
            3'd4: return m_count();
            3'd5: return {31'h0, m_expired};
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin : model
        logic        wr;
        logic [2:0]  a;
        logic [31:0] d;
        logic [31:0] nl;
        bit          cw;
        bit          expire;
        m_edge++;
        if (rst) begin
            m_running = 0;
            m_frozen  = 0;
            m_load    = 0;
            m_led     = 0;
            m_ctrl    = 0;
            m_expired = 0;
            m_state   = ST_IDLE;
            sw_q      = '{16'h0, 16'h0};
        end else begin
            wr     = io_ce_i && iowenb_i;
            a      = ioaddr_i[4:2];
            d      = io_wdata_i;
            nl     = (wr && a == 3'd3) ? d : m_load;
            cw     = wr && a == 3'd2;
            expire = 0;
            sw_q.push_back(switch_i);
            void'(sw_q.pop_front());
            if (m_running) begin
                if (cw && !d[0]) begin
                    m_frozen  = 32'(m_per - (m_edge - 1 - m_anchor));
                    m_running = 0;
                    m_state   = ST_IDLE;
                    m_ctrl    = d[2:0];
                end else begin
                    if (cw) m_ctrl = d[2:0];
                    // count was 0 before this edge once L+1 edges elapsed
                    if (m_edge - m_anchor == m_per + 1) begin
                        expire = 1;
                        if (m_ctrl[1]) begin
                            m_anchor = m_edge;
                            m_per    = longint'(nl);
                        end else begin
                            m_running = 0;
                            m_frozen  = 0;
                            m_ctrl[0] = 1'b0;
                            m_state   = ST_EXP;
                        end
                    end
                end
            end else if (cw) begin
                m_ctrl = d[2:0];
                if (d[0]) begin
                    m_running = 1;
                    m_anchor  = m_edge;
                    m_per     = longint'(nl);
                    m_state   = ST_RUN;
                end else begin
                    m_state = ST_IDLE;
                end
            end
            m_load = nl;
            if (wr && a == 3'd0) m_led = d[15:0];
            if (expire) m_expired = 1;
            else if (wr && a == 3'd5 && d[0]) m_expired = 0;
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        check("led_o", {16'h0, led_o}, {16'h0, m_led});
        check("irq_o", {31'h0, irq_o}, {31'h0, m_expired & m_ctrl[2]});
        check("state", {30'h0, dbg_state}, {30'h0, m_state});
    endtask

    // ---------------- drivers ----------------
    function automatic logic [31:0] mk_addr(input logic [31:0] base);
        logic [31:0] r;
        r = $urandom;
        r[4:2] = base[4:2];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic io_write(input logic [31:0] addr, input logic [31:0] data);
        ioaddr_i   = mk_addr(addr);
        io_wdata_i = data;
        io_ce_i    = 1'b1;
        iowenb_i   = 1'b1;
        #1;
        check("rdata_on_write", io_rdata_o, 32'h0);
        tick();
        io_ce_i    = 1'b0;
        iowenb_i   = 1'b0;
        io_wdata_i = $urandom;
    endtask

    task automatic read_model(input logic [31:0] addr);
        ioaddr_i = mk_addr(addr);
        io_ce_i  = 1'b1;
        iowenb_i = 1'b0;
        #1;
        check("read_model", io_rdata_o, m_read(addr[4:2]));
        io_ce_i = 1'b0;
        #1;
        check("rdata_idle", io_rdata_o, 32'h0);
    endtask

    task automatic read_expect(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        ioaddr_i = mk_addr(addr);
        io_ce_i  = 1'b1;
        iowenb_i = 1'b0;
        #1;
        check(tag, io_rdata_o, exp);
        io_ce_i = 1'b0;
        #1;
    endtask

    // ---------------- stimulus ----------------
    int unsigned r;
    logic [31:0] a_sel;
    logic [31:0] wd;
    logic [31:0] seq [6];

    initial begin
        rst        = 1'b1;
        io_ce_i    = 1'b0;
        iowenb_i   = 1'b0;
        ioaddr_i   = 32'h0;
        io_wdata_i = 32'h0;
        switch_i   = 16'h0;
        @(posedge clk);
        #1;
        tick();
        // reset state, read while reset is still asserted
        check("rst_led", {16'h0, led_o}, 32'h0);
        check("rst_irq", {31'h0, irq_o}, 32'h0);
        check("rst_state", {30'h0, dbg_state}, {30'h0, ST_IDLE});
        read_expect("rst_tctrl", AD_TCTRL, 32'h0);
        read_expect("rst_tload", AD_TLOAD, 32'h0);
        read_expect("rst_tcount", AD_TCOUNT, 32'h0);
        rst = 1'b0;
        tick();

        // LED write / read-back, unmapped read
        io_write(AD_LED, 32'h0000ABCD);
        check("led_abcd", {16'h0, led_o}, 32'h0000ABCD);
        read_expect("led_read", AD_LED, 32'h0000ABCD);
        read_expect("unmapped_0x18", 32'h18, 32'h0);

        // switch sync: change lands with edge 0, new value visible from edge 2
        switch_i = 16'h00F0;
        read_expect("sw_e0_old", AD_SW, 32'h0);
        tick();
        read_expect("sw_e1_old", AD_SW, 32'h0);
        tick();
        read_expect("sw_e2_new", AD_SW, 32'h00F0);

        // one-shot expiry, TLOAD = 3
        io_write(AD_TLOAD, 32'd3);
        io_write(AD_TCTRL, 32'b100);
        io_write(AD_TCTRL, 32'b101);
        read_expect("os_count0", AD_TCOUNT, 32'd3);
        for (int i = 1; i <= 4; i++) begin
            tick();
            if (i < 4) begin
                read_expect("os_not_yet", AD_TSTAT, 32'h0);
                check("os_irq_low", {31'h0, irq_o}, 32'h0);
            end
        end
        read_expect("os_expired", AD_TSTAT, 32'h1);
        check("os_irq", {31'h0, irq_o}, 32'h1);
        check("os_state", {30'h0, dbg_state}, {30'h0, ST_EXP});
        read_expect("os_tctrl", AD_TCTRL, 32'b100);
        read_expect("os_count_hold", AD_TCOUNT, 32'h0);
        io_write(AD_TSTAT, 32'h1);
        check("os_irq_clr", {31'h0, irq_o}, 32'h0);

        // autoreload, TLOAD = 2
        seq = '{32'd2, 32'd1, 32'd0, 32'd2, 32'd1, 32'd0};
        io_write(AD_TLOAD, 32'd2);
        io_write(AD_TCTRL, 32'b011);
        for (int i = 0; i < 6; i++) begin
            read_expect("ar_count", AD_TCOUNT, seq[i]);
            read_expect("ar_stat", AD_TSTAT, (i >= 3) ? 32'h1 : 32'h0);
            if (i < 5) tick();
        end
        io_write(AD_TCTRL, 32'b000);
        io_write(AD_TSTAT, 32'h1);
        read_expect("ar_cleared", AD_TSTAT, 32'h0);

        // clear-vs-set collision
        io_write(AD_TCTRL, 32'b111);
        tick();
        tick();
        io_write(AD_TSTAT, 32'h1);
        read_expect("coll_set_wins", AD_TSTAT, 32'h1);
        check("coll_irq", {31'h0, irq_o}, 32'h1);
        tick();
        io_write(AD_TSTAT, 32'h1);
        read_expect("coll_cleared", AD_TSTAT, 32'h0);
        check("coll_irq_low", {31'h0, irq_o}, 32'h0);
        io_write(AD_TCTRL, 32'b000);
        check("coll_idle", {30'h0, dbg_state}, {30'h0, ST_IDLE});

        // reset mid-run at TCOUNT = 5, with a concurrent LED write
        io_write(AD_TLOAD, 32'd8);
        io_write(AD_TCTRL, 32'b101);
        tick();
        tick();
        tick();
        read_expect("mr_count5", AD_TCOUNT, 32'd5);
        rst        = 1'b1;
        ioaddr_i   = AD_LED;
        io_wdata_i = 32'h1234;
        io_ce_i    = 1'b1;
        iowenb_i   = 1'b1;
        tick();
        io_ce_i  = 1'b0;
        iowenb_i = 1'b0;
        check("mr_led", {16'h0, led_o}, 32'h0);
        check("mr_irq", {31'h0, irq_o}, 32'h0);
        check("mr_state", {30'h0, dbg_state}, {30'h0, ST_IDLE});
        read_expect("mr_tctrl", AD_TCTRL, 32'h0);
        read_expect("mr_tload", AD_TLOAD, 32'h0);
        read_expect("mr_tcount", AD_TCOUNT, 32'h0);
        read_expect("mr_tstat", AD_TSTAT, 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            read_expect("mr_no_expire", AD_TSTAT, 32'h0);
        end

        // randomized traffic against the model
        for (int n = 0; n < 800; n++) begin
            r = $urandom_range(0, 99);
            a_sel = {27'h0, 3'($urandom_range(0, 7)), 2'b00};
            if (r < 2) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end else if (r < 10) begin
                switch_i = 16'($urandom);
                tick();
            end else if (r < 45) begin
                case (a_sel[4:2])
                    3'd2:    wd = {$urandom_range(0, 1) ? 29'h0 : 29'($urandom), 3'($urandom_range(0, 7))};
                    3'd3:    wd = 32'($urandom_range(0, 6));
                    default: wd = $urandom;
                endcase
                io_write(a_sel, wd);
            end else if (r < 75) begin
                read_model(a_sel);
                tick();
            end else begin
                tick();
            end
        end
        for (int k = 0; k < 8; k++) read_model({27'h0, 3'(k), 2'b00});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
